// File: rtl/cam_cmd_frontend.sv
// -----------------------------------------------------------------------------
// cam_cmd_frontend
//
// Command front end for a 32-entry CAM. Read/write/search commands arrive on a
// valid/ready stream, are buffered in a small FIFO and issued to the CAM one at
// a time. The CAM's registered result is captured and returned on a
// valid/ready response stream.
//
// Optional feature macro: CAM_FE_WRITE_ACK_EN
//   defined   : writes pass through CAPTURE/RESP and return an acknowledge
//               response (op=01, hit=1, index=cmd index, data=0).
//   undefined : writes produce no response; FSM returns to IDLE after ISSUE.
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   cmd_valid_i / cmd_ready_o    command handshake (ready = FIFO not full)
//   cmd_op_i                     00 read, 01 write, 10 search, 11 reserved
//   cmd_index_i, cmd_data_i      command index and data
//   resp_valid_o / resp_ready_i  response handshake
//   resp_op_o, resp_hit_o, resp_index_o, resp_data_o, resp_err_o
//                                response fields
//   fifo_count_o                 FIFO occupancy
//   cam_*_enable_o               one-cycle CAM strobes
//   cam_*_index_o, cam_*_data_o  CAM index/data (hold when strobes are low)
//   cam_read_valid_i, cam_read_value_i, cam_search_valid_i,
//   cam_search_index_i           CAM results, valid the cycle after a strobe
// -----------------------------------------------------------------------------
module cam_cmd_frontend #(
  parameter int FIFO_DEPTH = 4,
  parameter int INDEX_W    = 5,
  parameter int DATA_W     = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          cmd_valid_i,
  output logic                          cmd_ready_o,
  input  logic [1:0]                    cmd_op_i,
  input  logic [INDEX_W-1:0]            cmd_index_i,
  input  logic [DATA_W-1:0]             cmd_data_i,
  output logic                          resp_valid_o,
  input  logic                          resp_ready_i,
  output logic [1:0]                    resp_op_o,
  output logic                          resp_hit_o,
  output logic [INDEX_W-1:0]            resp_index_o,
  output logic [DATA_W-1:0]             resp_data_o,
  output logic                          resp_err_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          cam_read_enable_o,
  output logic                          cam_write_enable_o,
  output logic                          cam_search_enable_o,
  output logic [INDEX_W-1:0]            cam_read_index_o,
  output logic [INDEX_W-1:0]            cam_write_index_o,
  output logic [DATA_W-1:0]             cam_write_data_o,
  output logic [DATA_W-1:0]             cam_search_data_o,
  input  logic                          cam_read_valid_i,
  input  logic                          cam_search_valid_i,
  input  logic [DATA_W-1:0]             cam_read_value_i,
  input  logic [INDEX_W-1:0]            cam_search_index_i
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] OP_READ   = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_SEARCH = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_RESP} state_t;

  // FIFO storage (payload only, no reset needed)
  logic [1:0]         fifo_op_q   [FIFO_DEPTH];
  logic [INDEX_W-1:0] fifo_idx_q  [FIFO_DEPTH];
  logic [DATA_W-1:0]  fifo_data_q [FIFO_DEPTH];

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [1:0]         op_q, op_d;
  logic [INDEX_W-1:0] idx_q, idx_d;

  logic               rd_en_q, rd_en_d, wr_en_q, wr_en_d, srch_en_q, srch_en_d;
  logic [INDEX_W-1:0] rd_idx_q, rd_idx_d, wr_idx_q, wr_idx_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d, srch_data_q, srch_data_d;

  logic               resp_valid_q, resp_valid_d;
  logic [1:0]         resp_op_q, resp_op_d;
  logic               resp_hit_q, resp_hit_d;
  logic [INDEX_W-1:0] resp_index_q, resp_index_d;
  logic [DATA_W-1:0]  resp_data_q, resp_data_d;
  logic               resp_err_q, resp_err_d;

  logic               push, pop;
  logic [1:0]         head_op;
  logic [INDEX_W-1:0] head_idx;
  logic [DATA_W-1:0]  head_data;

  // Ready is derived from the registered count only; a same-cycle pop does
  // not free a slot for the incoming command.
  assign cmd_ready_o = (count_q < DEPTH_C);
  assign push        = cmd_valid_i && cmd_ready_o;
  assign head_op     = fifo_op_q[rd_ptr_q];
  assign head_idx    = fifo_idx_q[rd_ptr_q];
  assign head_data   = fifo_data_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_op_q[wr_ptr_q]   <= cmd_op_i;
      fifo_idx_q[wr_ptr_q]  <= cmd_index_i;
      fifo_data_q[wr_ptr_q] <= cmd_data_i;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    idx_d        = idx_q;
    rd_en_d      = 1'b0;
    wr_en_d      = 1'b0;
    srch_en_d    = 1'b0;
    rd_idx_d     = rd_idx_q;
    wr_idx_d     = wr_idx_q;
    wr_data_d    = wr_data_q;
    srch_data_d  = srch_data_q;
    resp_valid_d = resp_valid_q;
    resp_op_d    = resp_op_q;
    resp_hit_d   = resp_hit_q;
    resp_index_d = resp_index_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    pop          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop   = 1'b1;
          op_d  = head_op;
          idx_d = head_idx;
          case (head_op)
            OP_READ: begin
              rd_en_d  = 1'b1;
              rd_idx_d = head_idx;
              state_d  = S_ISSUE;
            end
            OP_WRITE: begin
              wr_en_d   = 1'b1;
              wr_idx_d  = head_idx;
              wr_data_d = head_data;
              state_d   = S_ISSUE;
            end
            OP_SEARCH: begin
              srch_en_d   = 1'b1;
              srch_data_d = head_data;
              state_d     = S_ISSUE;
            end
            default: begin
              // Reserved op: answer immediately with an error, CAM untouched.
              resp_valid_d = 1'b1;
              resp_op_d    = head_op;
              resp_hit_d   = 1'b0;
              resp_index_d = head_idx;
              resp_data_d  = '0;
              resp_err_d   = 1'b1;
              state_d      = S_RESP;
            end
          endcase
        end
      end

      S_ISSUE: begin
        if (op_q == OP_WRITE) begin
`ifdef CAM_FE_WRITE_ACK_EN
          state_d = S_CAPTURE;
`else
          state_d = S_IDLE;
`endif
        end else begin
          state_d = S_CAPTURE;
        end
      end

      S_CAPTURE: begin
        // CAM results are valid this cycle (one cycle after the strobe).
        resp_valid_d = 1'b1;
        resp_op_d    = op_q;
        resp_err_d   = 1'b0;
        case (op_q)
          OP_READ: begin
            resp_hit_d   = cam_read_valid_i;
            resp_index_d = idx_q;
            resp_data_d  = cam_read_value_i;
          end
          OP_SEARCH: begin
            resp_hit_d   = cam_search_valid_i;
            resp_index_d = cam_search_valid_i ? cam_search_index_i : '0;
            resp_data_d  = '0;
          end
          default: begin
            // Write acknowledge
            resp_hit_d   = 1'b1;
            resp_index_d = idx_q;
            resp_data_d  = '0;
          end
        endcase
        state_d = S_RESP;
      end

      S_RESP: begin
        if (resp_ready_i) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      op_q         <= '0;
      idx_q        <= '0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      srch_en_q    <= 1'b0;
      rd_idx_q     <= '0;
      wr_idx_q     <= '0;
      wr_data_q    <= '0;
      srch_data_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_op_q    <= '0;
      resp_hit_q   <= 1'b0;
      resp_index_q <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      op_q         <= op_d;
      idx_q        <= idx_d;
      rd_en_q      <= rd_en_d;
      wr_en_q      <= wr_en_d;
      srch_en_q    <= srch_en_d;
      rd_idx_q     <= rd_idx_d;
      wr_idx_q     <= wr_idx_d;
      wr_data_q    <= wr_data_d;
      srch_data_q  <= srch_data_d;
      resp_valid_q <= resp_valid_d;
      resp_op_q    <= resp_op_d;
      resp_hit_q   <= resp_hit_d;
      resp_index_q <= resp_index_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign fifo_count_o        = count_q;
  assign cam_read_enable_o   = rd_en_q;
  assign cam_write_enable_o  = wr_en_q;
  assign cam_search_enable_o = srch_en_q;
  assign cam_read_index_o    = rd_idx_q;
  assign cam_write_index_o   = wr_idx_q;
  assign cam_write_data_o    = wr_data_q;
  assign cam_search_data_o   = srch_data_q;
  assign resp_valid_o        = resp_valid_q;
  assign resp_op_o           = resp_op_q;
  assign resp_hit_o          = resp_hit_q;
  assign resp_index_o        = resp_index_q;
  assign resp_data_o         = resp_data_q;
  assign resp_err_o          = resp_err_q;

endmodule
